// File: rtl/decode_issue_stage.sv
// Registered decode/issue stage for the 8-bit NAND CPU: one-entry slot with valid/ready
// handshake, per-register scoreboard interlock, halt tracking and flush.
module decode_issue_stage #(
  parameter int PC_W     = 8,
  parameter int WB_PORTS = 2,
  parameter bit SB_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_instr,
  input  logic [PC_W-1:0]       in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_W-1:0]       out_pc,
  output logic                  use_ra,
  output logic                  use_rt,
  output logic                  use_rw,
  output logic                  read_ps,
  output logic                  write_ps,
  output logic                  use_immdt,
  output logic                  mem_access,
  output logic                  jump,
  output logic                  branch,
  output logic                  interrupt,
  output logic                  halt,
  output logic [3:0]            rt_addr,
  output logic [3:0]            rw_addr,
  output logic [3:0]            immdt,
  output logic [1:0]            shift,
  output logic                  mem_op,
  output logic [2:0]            alu_op,
  input  logic [WB_PORTS-1:0]   wb_valid,
  input  logic [4*WB_PORTS-1:0] wb_addr,
  input  logic                  ps_wb,
  output logic                  halted
);
  localparam logic [2:0] ALU_CLR = 3'd0, ALU_CP = 3'd1, ALU_NAND = 3'd2, ALU_LS = 3'd3,
                         ALU_RS = 3'd4, ALU_EQ = 3'd5, ALU_NE = 3'd6, ALU_LI = 3'd7;

  typedef struct packed {
    logic       use_ra, use_rt, use_rw, read_ps, write_ps, use_immdt;
    logic       mem_access, jump, branch, interrupt, halt;
    logic [3:0] rt_addr, rw_addr, immdt;
    logic [1:0] shift;
    logic       mem_op;
    logic [2:0] alu_op;
  } dec_t;

  dec_t            w_dec, r_dec;
  logic            r_slot_v, r_ps_pend, r_halted;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_pend, w_clr, w_set;
  logic            w_hazard, w_issue, w_accept;

  always_comb begin
    w_dec         = '0;
    w_dec.rt_addr = in_instr[3:0];
    w_dec.immdt   = in_instr[3:0];
    w_dec.shift   = in_instr[5:4];
    case (in_instr[7:4])
      4'h0: if (in_instr[3:0] == 4'h0) begin
              w_dec.use_rw = 1'b1; w_dec.alu_op = ALU_CLR;
            end else begin
              w_dec.use_ra = 1'b1; w_dec.use_rw = 1'b1;
              w_dec.rw_addr = in_instr[3:0]; w_dec.alu_op = ALU_CP;
            end
      4'h1: begin w_dec.use_ra = 1'b1; w_dec.use_rt = 1'b1; w_dec.use_rw = 1'b1; w_dec.alu_op = ALU_NAND; end
      4'h2: begin w_dec.use_ra = 1'b1; w_dec.use_rt = 1'b1; w_dec.use_rw = 1'b1; w_dec.alu_op = ALU_LS; end
      4'h3: begin w_dec.use_ra = 1'b1; w_dec.use_rt = 1'b1; w_dec.use_rw = 1'b1; w_dec.alu_op = ALU_RS; end
      4'h4, 4'h5: begin
              w_dec.use_ra = 1'b1; w_dec.use_rt = 1'b1; w_dec.write_ps = 1'b1;
              w_dec.alu_op = in_instr[4] ? ALU_NE : ALU_EQ;
            end
      4'h6: begin w_dec.use_rt = 1'b1; w_dec.read_ps = 1'b1; w_dec.branch = 1'b1; end
      4'h7: begin
              w_dec.use_rt = 1'b1; w_dec.use_rw = 1'b1;
              w_dec.rw_addr = in_instr[3:0]; w_dec.jump = 1'b1;
            end
      4'h8, 4'h9, 4'hA, 4'hB: begin
              w_dec.use_ra = 1'b1; w_dec.use_rw = 1'b1; w_dec.use_immdt = 1'b1; w_dec.alu_op = ALU_LI;
            end
      4'hC: begin w_dec.use_rt = 1'b1; w_dec.use_rw = 1'b1; w_dec.mem_access = 1'b1; end
      4'hD: begin w_dec.use_ra = 1'b1; w_dec.use_rt = 1'b1; w_dec.mem_access = 1'b1; w_dec.mem_op = 1'b1; end
      4'hE: begin w_dec.use_immdt = 1'b1; w_dec.interrupt = 1'b1; end
      default: begin w_dec.use_immdt = 1'b1; w_dec.halt = 1'b1; end
    endcase
  end

  // ra is hardwired to r0; the rw term guards against write-after-write
  assign w_hazard = (r_dec.use_ra && r_pend[0]) || (r_dec.use_rt && r_pend[r_dec.rt_addr]) ||
                    (r_dec.read_ps && r_ps_pend) || (r_dec.use_rw && r_pend[r_dec.rw_addr]);
  assign out_valid = r_slot_v && !(SB_EN && w_hazard);
  assign w_issue   = out_valid && out_ready;
  // a HLT leaving the slot must not let a follower in behind it
  assign in_ready  = !r_halted && !flush && (!r_slot_v || (w_issue && !r_dec.halt));
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int k = 0; k < WB_PORTS; k++)
      if (wb_valid[k]) w_clr[wb_addr[4*k +: 4]] = 1'b1;
    if (w_issue && r_dec.use_rw) w_set[r_dec.rw_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_slot_v  <= 1'b0;
      r_dec     <= '0;
      r_pc      <= '0;
      r_pend    <= '0;
      r_ps_pend <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_pend    <= (r_pend & ~w_clr) | w_set;
      r_ps_pend <= (r_ps_pend && !ps_wb) || (w_issue && r_dec.write_ps);
      if (w_issue && r_dec.halt) r_halted <= 1'b1;
      if (flush) r_slot_v <= 1'b0;
      else if (w_accept) begin
        r_slot_v <= 1'b1;
        r_dec    <= w_dec;
        r_pc     <= in_pc;
      end else if (w_issue) r_slot_v <= 1'b0;
    end
  end

  assign out_pc     = r_pc;
  assign use_ra     = r_dec.use_ra;
  assign use_rt     = r_dec.use_rt;
  assign use_rw     = r_dec.use_rw;
  assign read_ps    = r_dec.read_ps;
  assign write_ps   = r_dec.write_ps;
  assign use_immdt  = r_dec.use_immdt;
  assign mem_access = r_dec.mem_access;
  assign jump       = r_dec.jump;
  assign branch     = r_dec.branch;
  assign interrupt  = r_dec.interrupt;
  assign halt       = r_dec.halt;
  assign rt_addr    = r_dec.rt_addr;
  assign rw_addr    = r_dec.rw_addr;
  assign immdt      = r_dec.immdt;
  assign shift      = r_dec.shift;
  assign mem_op     = r_dec.mem_op;
  assign alu_op     = r_dec.alu_op;
  assign halted     = r_halted;
endmodule
